// File: rtl/t03_bit_entry_pkg.sv
// Shared types and default sizing for the pushbutton bit-entry front end.
// The defaults are reused by the downstream shift/latch register instantiation.
package t03_bit_entry_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } t03_state_t;

   localparam int T03_DEBOUNCE_CYCLES = 100000;
   localparam int T03_WORD_BITS       = 8;

endpackage

// File: rtl/t03_btn_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter and rising-edge detect.
// rise_pulse is decoded from registers only, so nothing combinational reaches it from raw.
module t03_btn_debounce #(
   parameter  int DEBOUNCE_CYCLES = 100000,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic nrst,
   input  logic raw,
   output logic stable,
   output logic rise_pulse
);

   logic             sync_q1;
   logic             sync_q2;
   logic             stable_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync_q1  <= 1'b0;
         sync_q2  <= 1'b0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= '0;
      end else begin
         sync_q1  <= raw;
         sync_q2  <= sync_q1;
         stable_d <= stable;
         // any cycle that agrees with the accepted level restarts the qualification
         if (sync_q2 != stable) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               stable <= sync_q2;
               cnt    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign rise_pulse = stable & ~stable_d;

endmodule

// File: rtl/t03_bit_entry_ctrl.sv
// Turns debounced "0"/"1"/"clear" presses into serial shift strobes and a word latch strobe.
// state   | meaning
// IDLE    | no bits entered yet (bit_count = 0)
// COLLECT | word partially entered, waiting for the next bit or clear
// DONE    | last bit shifted; one cycle emitting finished, inputs ignored
module t03_bit_entry_ctrl
   import t03_bit_entry_pkg::*;
#(
   parameter  int DEBOUNCE_CYCLES = T03_DEBOUNCE_CYCLES,
   parameter  int WORD_BITS       = T03_WORD_BITS,
   localparam int CNT_W           = $clog2(WORD_BITS + 1)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             btn_zero,
   input  logic             btn_one,
   input  logic             btn_clear,
   output logic             data,
   output logic             button_en,
   output logic             finished,
   output logic [CNT_W-1:0] bit_count,
   output logic             busy
);

   if (WORD_BITS < 2) begin : g_bad_word_bits
      $error("t03_bit_entry_ctrl: WORD_BITS must be at least 2");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("t03_bit_entry_ctrl: DEBOUNCE_CYCLES must be at least 2");
   end

   t03_state_t state;
   logic       zero_evt;
   logic       one_evt;
   logic       clear_evt;
   logic       zero_level;
   logic       one_level;
   logic       clear_level;
   logic       bit_evt;

   t03_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_zero (
      .clk        (clk),
      .nrst       (nrst),
      .raw        (btn_zero),
      .stable     (zero_level),
      .rise_pulse (zero_evt)
   );

   t03_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_one (
      .clk        (clk),
      .nrst       (nrst),
      .raw        (btn_one),
      .stable     (one_level),
      .rise_pulse (one_evt)
   );

   t03_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
      .clk        (clk),
      .nrst       (nrst),
      .raw        (btn_clear),
      .stable     (clear_level),
      .rise_pulse (clear_evt)
   );

   // simultaneous 0 and 1 presses are ambiguous and dropped together
   assign bit_evt = zero_evt ^ one_evt;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= IDLE;
         data      <= 1'b0;
         button_en <= 1'b0;
         finished  <= 1'b0;
         bit_count <= '0;
         busy      <= 1'b0;
      end else begin
         data      <= 1'b0;
         button_en <= 1'b0;
         finished  <= 1'b0;
         case (state)
            IDLE, COLLECT: begin
               if (clear_evt) begin
                  bit_count <= '0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (bit_evt) begin
                  button_en <= 1'b1;
                  data      <= one_evt;
                  bit_count <= bit_count + 1'b1;
                  if (bit_count == CNT_W'(WORD_BITS - 1)) begin
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= COLLECT;
                  end
               end
            end
            DONE: begin
               finished  <= 1'b1;
               bit_count <= '0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               bit_count <= '0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   logic unused_levels;
   assign unused_levels = zero_level ^ one_level ^ clear_level;

endmodule
